mem_access_stage: RTL
=====================

// Module: mem_access_stage
// PURPOSE
//  Memory stage plus the MEM/WB pipeline register. It sits directly upstream of the writeback
//  mux and issues loads/stores to data memory over a req/gnt/rvalid handshake.
//  Stalls the pipeline while an access is outstanding. Formats load data (LB/LH/LW/LBU/LHU)
//  and store byte enables. Registers ReadDataW, ALUResultW, PCPlus4W, RdW, RegWriteW and ResultSrcW.
// PARAMETERS
//  WIDTH     32  datapath/address width
//  REG_ADDR  5   register-file index width
// PORTS
//  clk          in   1        clock, all state on rising edge
//  rst          in   1        synchronous reset, active-high
//  ValidM       in   1        instruction in MEM stage is valid
//  MemReadM     in   1        load
//  MemWriteM    in   1        store
//  Funct3M      in   3        size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  ALUResultM   in   WIDTH    effective address / ALU result
//  WriteDataM   in   WIDTH    store data, unshifted
//  PCPlus4M     in   WIDTH    PC+4 for JAL/JALR
//  RdM          in   REG_ADDR destination register
//  RegWriteM    in   1        writes register file
//  ResultSrcM   in   2        passed through to ResultSrcW
//  mem_req      out  1        access request
//  mem_we       out  1        1 = store
//  mem_addr     out  WIDTH    word-aligned address {ALUResultM[WIDTH-1:2],2'b00}
//  mem_wdata    out  WIDTH    store data shifted to byte lane
//  mem_be       out  4        byte enables
//  mem_gnt      in   1        request accepted this cycle
//  mem_rvalid   in   1        load data valid (earliest cycle after gnt)
//  mem_rdata    in   WIDTH    raw load word
//  StallM       out  1        freeze PC/IF/ID/EX/MEM registers
//  MisalignM    out  1        misaligned access pulse (1 cycle)
//  ReadDataW, ALUResultW, PCPlus4W  out WIDTH
//  RdW          out  REG_ADDR
//  RegWriteW    out  1
//  ResultSrcW   out  2
// BEHAVIOUR
//  - FSM IDLE/REQ/WAIT. acc = ValidM & (MemReadM|MemWriteM) & ~misalign.
//  - IDLE: mem_req = acc (combinational). gnt&store -> stays IDLE, done. gnt&load -> WAIT.
//    ~gnt -> REQ.
//  - REQ: mem_req=1, address/data/be held stable; gnt -> IDLE (store) or WAIT (load).
//  - WAIT: mem_req=0; rvalid -> IDLE, done.
//  - StallM = acc & ~done, where done = (store granted this cycle) | (rvalid in WAIT).
//  - Store with immediate gnt: 0 stall cycles. Load with immediate gnt and rvalid next
//    cycle: 1 stall cycle.
//  - MEM/WB register: loads all inputs when ~StallM. RegWriteW = ValidM&RegWriteM&~misalign.
//    While StallM=1 it loads a bubble (RegWriteW=0, other fields don't-care), so W never
//    re-commits a stalled instruction.
//  - Non-memory instructions: 1-cycle latency M->W, never stall.
//  - Misalign: H with addr[0]=1, or W with addr[1:0]!=0. Effects: no mem_req, MisalignM=1
//    for that cycle, RegWriteW=0, no stall.
//  - Store lanes:
//      B:  be=0001<<a[1:0], wdata={4{wd[7:0]}}
//      H:  be=0011<<a[1:0], wdata={2{wd[15:0]}}
//      W:  be=1111
//  - Loads: byte/half selected by addr[1:0] latched at request time; sign- or zero-extended
//    per Funct3. Unsupported Funct3 is treated as W.
//  - mem_be=0 and mem_we=0 whenever mem_req=0.
//  - rvalid outside WAIT is ignored. gnt outside a request is ignored.
//  - Reset (also mid-access): state->IDLE; mem_req=0; StallM=0; MisalignM=0; all W outputs 0.
//    Data memory shares rst, so no stale rvalid is expected.
// TESTING
//  1. ADD: ALUResultM=0x1234, RegWriteM=1, RdM=5 -> next cycle ALUResultW=0x1234, RdW=5,
//     RegWriteW=1, no stall.
//  2. LB at 0x103, gnt same cycle, rdata=0x80FF_FF00 next cycle -> 1 stall cycle;
//     ReadDataW=0xFFFF_FF80. Same access as LBU -> 0x0000_0080.
//  3. SH at 0x102, wd=0xABCD, gnt delayed 3 cycles -> StallM for 3 cycles; mem_be=1100 and
//     wdata=0xABCD_ABCD held stable throughout; RegWriteW=0.
//  4. LW at 0x201 -> no mem_req, MisalignM=1 for 1 cycle, RegWriteW=0.
//  5. LW with rvalid 4 cycles after gnt; rst asserted in the 2nd WAIT cycle -> next cycle
//     IDLE, StallM=0, W outputs 0; late rvalid ignored.
//  6. Back-to-back SW then LW, both with immediate gnt -> SW commits with 0 stall; LW stalls
//     1 cycle; W sequence is correct with no duplicate RegWriteW.

Source files
------------

// File: rtl/mem_access_stage.sv
// mem_access_stage: memory stage of the core plus the MEM/WB pipeline register.
// Issues loads/stores over a req/gnt/rvalid handshake, holds the pipeline while an
// access is outstanding, places store data on byte lanes and extracts load data.
module mem_access_stage #(
  parameter int WIDTH    = 32,
  parameter int REG_ADDR = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ValidM,
  input  logic                MemReadM,
  input  logic                MemWriteM,
  input  logic [2:0]          Funct3M,
  input  logic [WIDTH-1:0]    ALUResultM,
  input  logic [WIDTH-1:0]    WriteDataM,
  input  logic [WIDTH-1:0]    PCPlus4M,
  input  logic [REG_ADDR-1:0] RdM,
  input  logic                RegWriteM,
  input  logic [1:0]          ResultSrcM,
  output logic                mem_req,
  output logic                mem_we,
  output logic [WIDTH-1:0]    mem_addr,
  output logic [WIDTH-1:0]    mem_wdata,
  output logic [3:0]          mem_be,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [WIDTH-1:0]    mem_rdata,
  output logic                StallM,
  output logic                MisalignM,
  output logic [WIDTH-1:0]    ReadDataW,
  output logic [WIDTH-1:0]    ALUResultW,
  output logic [WIDTH-1:0]    PCPlus4W,
  output logic [REG_ADDR-1:0] RdW,
  output logic                RegWriteW,
  output logic [1:0]          ResultSrcW
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t           state, state_nxt;
  logic             is_mem, size_b, size_h, misal, acc, is_store, done, load_issue;
  logic [1:0]       off;
  logic [3:0]       be_raw;
  logic [WIDTH-1:0] wdata_raw, rd_fmt;
  logic [1:0]       off_p0;
  logic [2:0]       f3_p0;

  // Byte/half extraction with sign or zero extension; anything else returns the word.
  function automatic logic [WIDTH-1:0] fmt_load(input logic [WIDTH-1:0] raw,
                                                input logic [2:0] f3,
                                                input logic [1:0] o);
    logic [7:0]         b;
    logic [15:0]        h;
    logic signed [7:0]  bs;
    logic signed [15:0] hs;
    logic signed [WIDTH-1:0] ext;
    b  = 8'(raw >> {o, 3'b000});
    h  = o[1] ? raw[31:16] : raw[15:0];
    bs = signed'(b);
    hs = signed'(h);
    case (f3)
      3'b000:  begin ext = WIDTH'(bs); return unsigned'(ext); end
      3'b001:  begin ext = WIDTH'(hs); return unsigned'(ext); end
      3'b100:  return WIDTH'(b);
      3'b101:  return WIDTH'(h);
      default: return raw;
    endcase
  endfunction

  assign off      = ALUResultM[1:0];
  assign size_b   = (Funct3M == 3'b000) || (Funct3M == 3'b100);
  assign size_h   = (Funct3M == 3'b001) || (Funct3M == 3'b101);
  // Reset masks the request path so nothing is issued or stalled during the reset cycle.
  assign is_mem   = ~rst & ValidM & (MemReadM | MemWriteM);
  assign misal    = size_h ? off[0] : (~size_b & (off != 2'b00));
  assign acc      = is_mem & ~misal;
  assign is_store = MemWriteM;

  assign MisalignM = is_mem & misal;
  assign StallM    = acc & ~done;

  assign be_raw    = size_b ? (4'b0001 << off) : size_h ? (4'b0011 << off) : 4'b1111;
  assign wdata_raw = size_b ? {(WIDTH/8){WriteDataM[7:0]}} :
                     size_h ? {(WIDTH/16){WriteDataM[15:0]}} : WriteDataM;

  // Address/data come straight from the MEM register, which StallM keeps frozen in REQ.
  assign mem_addr   = {ALUResultM[WIDTH-1:2], 2'b00};
  assign mem_wdata  = wdata_raw;
  assign mem_we     = mem_req & is_store;
  assign mem_be     = mem_req ? be_raw : 4'b0000;
  assign load_issue = mem_req & mem_gnt & ~is_store;

  // Only a response arriving in WAIT is meaningful; stray rvalid never reaches W.
  assign rd_fmt = (state == WAIT) ? fmt_load(mem_rdata, f3_p0, off_p0) : '0;

  // Handshake next-state and request/done decode.
  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        mem_req = acc;
        if (acc) begin
          if (mem_gnt) begin
            if (is_store) done = 1'b1;
            else          state_nxt = WAIT;
          end else begin
            state_nxt = REQ;
          end
        end
      end
      REQ: begin
        mem_req = ~rst;
        if (mem_gnt) begin
          if (is_store) begin
            done      = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // ---- request -> response boundary: capture lane and size when a load is accepted ----
  always_ff @(posedge clk) begin
    if (load_issue) begin
      off_p0 <= off;
      f3_p0  <= Funct3M;
    end
  end

  // ---- MEM/WB boundary: commit when not stalled, insert a bubble while stalled ----
  always_ff @(posedge clk) begin
    if (rst) begin
      ReadDataW  <= '0;
      ALUResultW <= '0;
      PCPlus4W   <= '0;
      RdW        <= '0;
      RegWriteW  <= 1'b0;
      ResultSrcW <= '0;
    end else if (StallM) begin
      RegWriteW  <= 1'b0;
    end else begin
      ReadDataW  <= rd_fmt;
      ALUResultW <= ALUResultM;
      PCPlus4W   <= PCPlus4M;
      RdW        <= RdM;
      RegWriteW  <= ValidM & RegWriteM & ~MisalignM;
      ResultSrcW <= ResultSrcM;
    end
  end

endmodule
